// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Processor front end. Fetches instruction words (and the
//            immediate word of MVI) from instruction memory, holds them in
//            iin/din, and runs the 2-bit step counter for the control unit.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
   parameter int          IW     = 9,
   parameter int          AW     = 5,
   parameter logic [2:0]  OP_MVI = 3'b001
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          run,
   input  logic [IW-1:0] mem_rdata,
   input  logic          mem_valid,
   input  logic          clear,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [IW-1:0] iin,
   output logic [1:0]    count,
   output logic [IW-1:0] din,
   output logic          busy,
   output logic          overflow
);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_FETCH     = 2'd1;
   localparam logic [1:0] S_FETCH_IMM = 2'd2;
   localparam logic [1:0] S_EXEC      = 2'd3;

   localparam logic [1:0] C_COUNT_MAX = 2'd3;

   logic [1:0]    r_state;
   logic [AW-1:0] r_pc;
   logic [IW-1:0] r_iin;
   logic [IW-1:0] r_din;
   logic [1:0]    r_count;
   logic          r_mem_req;
   logic          r_busy;
   logic          r_overflow;

   logic [1:0]    w_state_nxt;
   logic [AW-1:0] w_pc_nxt;
   logic [IW-1:0] w_iin_nxt;
   logic [IW-1:0] w_din_nxt;
   logic [1:0]    w_count_nxt;
   logic          w_mem_req_nxt;
   logic          w_busy_nxt;
   logic          w_overflow_nxt;

   // Opcode field of the word currently on the memory read bus.
   logic          w_is_mvi;
   assign w_is_mvi = (mem_rdata[IW-1 -: 3] == OP_MVI);

   // State and output registers; every output comes straight from a flop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_iin      <= '0;
         r_din      <= '0;
         r_count    <= '0;
         r_mem_req  <= 1'b0;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_iin      <= w_iin_nxt;
         r_din      <= w_din_nxt;
         r_count    <= w_count_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_busy     <= w_busy_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   // Next-state decode: run is only consulted from IDLE and when leaving EXEC.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem_valid) begin
               w_state_nxt = w_is_mvi ? S_FETCH_IMM : S_EXEC;
            end
         end
         S_FETCH_IMM: begin
            if (mem_valid) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            // clear takes priority over the runaway-counter abort
            if (clear) begin
               w_state_nxt = run ? S_FETCH : S_IDLE;
            end else if (r_count == C_COUNT_MAX) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values for the registered outputs and the datapath registers.
   always_comb begin
      w_pc_nxt       = r_pc;
      w_iin_nxt      = r_iin;
      w_din_nxt      = r_din;
      w_count_nxt    = '0;
      w_overflow_nxt = r_overflow;
      case (r_state)
         S_FETCH: begin
            if (mem_valid) begin
               w_iin_nxt = mem_rdata;
               w_pc_nxt  = r_pc + 1'b1;
            end
         end
         S_FETCH_IMM: begin
            if (mem_valid) begin
               w_din_nxt = mem_rdata;
               w_pc_nxt  = r_pc + 1'b1;
            end
         end
         S_EXEC: begin
            if (clear) begin
               w_count_nxt = '0;
            end else if (r_count == C_COUNT_MAX) begin
               // control unit never ended the instruction: flag it and give up
               w_overflow_nxt = 1'b1;
               w_count_nxt    = '0;
            end else begin
               w_count_nxt = r_count + 2'd1;
            end
         end
         default: begin
            w_count_nxt = '0;
         end
      endcase
      // Request and busy are decoded from the upcoming state so they are
      // registered yet line up with the state they describe.
      w_mem_req_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_FETCH_IMM);
      w_busy_nxt    = (w_state_nxt != S_IDLE);
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_pc;
   assign iin      = r_iin;
   assign din      = r_din;
   assign count    = r_count;
   assign busy     = r_busy;
   assign overflow = r_overflow;

endmodule
`default_nettype wire
